common_acc_fixed: RTL and testbench

Fixed-point frame accumulator placed directly downstream of common_madd_fixed.
- Consumes its out/user/valid/ready stream and sums a programmable number of samples per frame.
- Converts the sum to the output fixed-point format with optional rounding and saturation.
- Emits one result per frame on the same valid/ready handshake, so multiply-accumulate chains such as dot products and FIR taps can be built.

---
 rtl/common_acc_fixed_if.sv | 29 ++
 rtl/common_acc_fixed.sv | 148 ++++++++++++++
 tb/tb_common_acc_fixed.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/common_acc_fixed_if.sv
// Stream bundle between common_madd_fixed and common_acc_fixed: a sample stream
// in, one converted result per frame out, each side with its own valid/ready pair.
interface common_acc_fixed_if #(
    parameter int U_WIDTH   = 16,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32,
    parameter int LEN_WIDTH = 8
);
    logic [IN_WIDTH-1:0]  in_i;
    logic [U_WIDTH-1:0]   user_i;
    logic [LEN_WIDTH-1:0] len_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [OUT_WIDTH-1:0] out_o;
    logic [U_WIDTH-1:0]   user_o;
    logic                 sat_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        output in_i, user_i, len_i, valid_i, ready_i,
        input  ready_o, out_o, user_o, sat_o, valid_o
    );

    modport slave (
        input  in_i, user_i, len_i, valid_i, ready_i,
        output ready_o, out_o, user_o, sat_o, valid_o
    );
endinterface

// File: rtl/common_acc_fixed.sv
// Frame accumulator: sums len_i samples, rescales the sum to the output fixed-point
// format with optional rounding and clamping, and emits one result per frame.
module common_acc_fixed #(
    parameter int U_WIDTH    = 16,
    parameter int IN_WIDTH   = 32,
    parameter int IN_POINT   = 16,
    parameter int IN_SIGNED  = 0,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_POINT  = 16,
    parameter int OUT_SIGNED = 0,
    parameter int LEN_WIDTH  = 8,
    parameter int ROUND      = 0
) (
    input logic clk,
    input logic rstn,
    common_acc_fixed_if.slave bus
);
    localparam int ACC_W = IN_WIDTH + LEN_WIDTH + 1;
    localparam int D     = IN_POINT - OUT_POINT;
    localparam int RSH   = (D > 0) ? D : 0;
    localparam int LSH   = (D < 0) ? -D : 0;
    // Wide enough for the left-shifted sum and for both clamp limits as signed values.
    localparam int CW0   = ACC_W + LSH + 1;
    localparam int CW    = (CW0 > OUT_WIDTH + 2) ? CW0 : OUT_WIDTH + 2;

    localparam logic signed [CW-1:0] ONE   = 1;
    localparam logic signed [CW-1:0] HALF  = (ROUND != 0 && RSH > 0) ?
                                             (ONE <<< ((RSH > 0) ? RSH - 1 : 0)) : {CW{1'b0}};
    localparam logic signed [CW-1:0] MAX_V = (OUT_SIGNED != 0) ?
                                             (ONE <<< (OUT_WIDTH - 1)) - ONE :
                                             (ONE <<< OUT_WIDTH) - ONE;
    localparam logic signed [CW-1:0] MIN_V = (OUT_SIGNED != 0) ?
                                             -(ONE <<< (OUT_WIDTH - 1)) : {CW{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg;
    logic [LEN_WIDTH-1:0]    cnt_reg;
    logic [LEN_WIDTH-1:0]    len_reg;
    logic [OUT_WIDTH-1:0]    out_reg;
    logic [U_WIDTH-1:0]      user_reg;
    logic                    sat_reg;
    logic                    valid_reg;

    logic                    accept;
    logic                    last;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic [LEN_WIDTH-1:0]    len_next;
    logic [LEN_WIDTH-1:0]    cnt_next;
    logic signed [CW-1:0]    wide;
    logic signed [CW-1:0]    shifted;
    logic [OUT_WIDTH-1:0]    conv_out;
    logic                    conv_sat;

    assign bus.ready_o = !valid_reg || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign len_eff     = (bus.len_i == '0) ? LEN_ONE : bus.len_i;

    generate
        if (IN_SIGNED != 0) begin : g_in_sext
            assign in_ext = {{(ACC_W - IN_WIDTH){bus.in_i[IN_WIDTH-1]}}, bus.in_i};
        end else begin : g_in_zext
            assign in_ext = {{(ACC_W - IN_WIDTH){1'b0}}, bus.in_i};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        acc_next   = in_ext;
        len_next   = len_eff;
        cnt_next   = LEN_ONE;
        case (state_reg)
            IDLE: begin
                acc_next = in_ext;
                len_next = len_eff;
                cnt_next = LEN_ONE;
            end
            ACC: begin
                acc_next = acc_reg + in_ext;
                len_next = len_reg;
                cnt_next = cnt_reg + LEN_ONE;
            end
            default: ;
        endcase
        last = (cnt_next == len_next);
        if (accept) begin
            state_next = last ? IDLE : ACC;
        end
    end

    // An unsigned sum never sets the accumulator MSB, so one signed path serves both input modes.
    assign wide    = {{(CW - ACC_W){acc_next[ACC_W-1]}}, acc_next};
    assign shifted = ((wide + HALF) >>> RSH) <<< LSH;

    always_comb begin
        conv_out = shifted[OUT_WIDTH-1:0];
        conv_sat = 1'b0;
        if (shifted > MAX_V) begin
            conv_out = MAX_V[OUT_WIDTH-1:0];
            conv_sat = 1'b1;
        end else if (shifted < MIN_V) begin
            conv_out = MIN_V[OUT_WIDTH-1:0];
            conv_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_next;
                len_reg <= len_next;
            end
        end
    end

    // A completing beat reloads the result even while the previous one is being taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_reg   <= '0;
            user_reg  <= '0;
            sat_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else if (accept && last) begin
            out_reg   <= conv_out;
            user_reg  <= bus.user_i;
            sat_reg   <= conv_sat;
            valid_reg <= 1'b1;
        end else if (bus.ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.out_o   = out_reg;
    assign bus.user_o  = user_reg;
    assign bus.sat_o   = sat_reg;
    assign bus.valid_o = valid_reg;
endmodule

// File: tb/tb_common_acc_fixed.sv
// Directed bench for common_acc_fixed: default-format frames, stalls, clamping,
// zero length, rounding, signed conversion and asynchronous reset mid-frame.
module tb_common_acc_fixed;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    common_acc_fixed_if bus0 ();
    common_acc_fixed_if bus_r1 ();
    common_acc_fixed_if bus_r0 ();
    common_acc_fixed_if bus_su ();
    common_acc_fixed_if bus_ss ();

    common_acc_fixed u_dut (.clk(clk), .rstn(rstn), .bus(bus0));
    common_acc_fixed #(.OUT_POINT(8), .ROUND(1)) u_dut_r1 (.clk(clk), .rstn(rstn), .bus(bus_r1));
    common_acc_fixed #(.OUT_POINT(8), .ROUND(0)) u_dut_r0 (.clk(clk), .rstn(rstn), .bus(bus_r0));
    common_acc_fixed #(.IN_SIGNED(1), .OUT_SIGNED(0)) u_dut_su (.clk(clk), .rstn(rstn), .bus(bus_su));
    common_acc_fixed #(.IN_SIGNED(1), .OUT_SIGNED(1)) u_dut_ss (.clk(clk), .rstn(rstn), .bus(bus_ss));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One beat on the main stream; waits (bounded) until the DUT can take it.
    task automatic send(input logic [31:0] d, input logic [15:0] u, input logic [7:0] l);
        bus0.in_i    = d;
        bus0.user_i  = u;
        bus0.len_i   = l;
        bus0.valid_i = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (bus0.ready_o) break;
            if (n == 20) begin
                check_val("send_timeout", 64'd0, 64'd1);
                bus0.valid_i = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus0.valid_i = 1'b0;
        $display("beat in=0x%08h user=0x%04h len=%0d", d, u, l);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] eo,
                               input logic [15:0] eu, input logic es);
        $display("frame %s out=0x%08h user=0x%04h sat=%0d valid=%0d",
                 tag, bus0.out_o, bus0.user_o, bus0.sat_o, bus0.valid_o);
        check_val({tag, "_valid"}, 64'(bus0.valid_o), 64'd1);
        check_val({tag, "_out"},   64'(bus0.out_o),   64'(eo));
        check_val({tag, "_user"},  64'(bus0.user_o),  64'(eu));
        check_val({tag, "_sat"},   64'(bus0.sat_o),   64'(es));
    endtask

    initial begin
        bus0.in_i = '0;   bus0.user_i = '0;   bus0.len_i = '0;   bus0.valid_i = 1'b0;   bus0.ready_i = 1'b1;
        bus_r1.in_i = '0; bus_r1.user_i = '0; bus_r1.len_i = '0; bus_r1.valid_i = 1'b0; bus_r1.ready_i = 1'b1;
        bus_r0.in_i = '0; bus_r0.user_i = '0; bus_r0.len_i = '0; bus_r0.valid_i = 1'b0; bus_r0.ready_i = 1'b1;
        bus_su.in_i = '0; bus_su.user_i = '0; bus_su.len_i = '0; bus_su.valid_i = 1'b0; bus_su.ready_i = 1'b1;
        bus_ss.in_i = '0; bus_ss.user_i = '0; bus_ss.len_i = '0; bus_ss.valid_i = 1'b0; bus_ss.ready_i = 1'b1;

        #2;
        check_val("rst_valid", 64'(bus0.valid_o), 64'd0);
        check_val("rst_out",   64'(bus0.out_o),   64'd0);
        check_val("rst_user",  64'(bus0.user_o),  64'd0);
        check_val("rst_sat",   64'(bus0.sat_o),   64'd0);
        #21 rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("idle_ready", 64'(bus0.ready_o), 64'd1);

        // Rounding variants: 0x80 with 8 bits dropped -> 0.5 LSB.
        bus_r1.in_i = 32'h0000_0080; bus_r1.len_i = 8'd1; bus_r1.user_i = 16'h0055; bus_r1.valid_i = 1'b1;
        bus_r0.in_i = 32'h0000_0080; bus_r0.len_i = 8'd1; bus_r0.user_i = 16'h0066; bus_r0.valid_i = 1'b1;
        // Signed sum -1.0 + 0.5 = -0.5.
        bus_su.in_i = 32'hFFFF_0000; bus_su.len_i = 8'd2; bus_su.user_i = 16'h0001; bus_su.valid_i = 1'b1;
        bus_ss.in_i = 32'hFFFF_0000; bus_ss.len_i = 8'd2; bus_ss.user_i = 16'h0001; bus_ss.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus_r1.valid_i = 1'b0;
        bus_r0.valid_i = 1'b0;
        $display("round r1 out=0x%08h r0 out=0x%08h", bus_r1.out_o, bus_r0.out_o);
        check_val("r1_valid", 64'(bus_r1.valid_o), 64'd1);
        check_val("r1_out",   64'(bus_r1.out_o),   64'h1);
        check_val("r0_valid", 64'(bus_r0.valid_o), 64'd1);
        check_val("r0_out",   64'(bus_r0.out_o),   64'h0);
        check_val("r0_user",  64'(bus_r0.user_o),  64'h66);
        bus_su.in_i = 32'h0000_8000; bus_su.user_i = 16'h0002;
        bus_ss.in_i = 32'h0000_8000; bus_ss.user_i = 16'h0002;
        @(posedge clk);
        #1;
        bus_su.valid_i = 1'b0;
        bus_ss.valid_i = 1'b0;
        $display("signed su out=0x%08h sat=%0d ss out=0x%08h sat=%0d",
                 bus_su.out_o, bus_su.sat_o, bus_ss.out_o, bus_ss.sat_o);
        check_val("su_valid", 64'(bus_su.valid_o), 64'd1);
        check_val("su_out",   64'(bus_su.out_o),   64'h0);
        check_val("su_sat",   64'(bus_su.sat_o),   64'd1);
        check_val("su_user",  64'(bus_su.user_o),  64'h2);
        check_val("ss_out",   64'(bus_ss.out_o),   64'hFFFF_8000);
        check_val("ss_sat",   64'(bus_ss.sat_o),   64'd0);

        // Four 1.0 samples, no gaps, sink always ready.
        send(32'h0001_0000, 16'd1, 8'd4);
        send(32'h0001_0000, 16'd2, 8'd4);
        send(32'h0001_0000, 16'd3, 8'd4);
        check_val("f1_early_valid", 64'(bus0.valid_o), 64'd0);
        send(32'h0001_0000, 16'd4, 8'd4);
        check_frame("f1", 32'h0004_0000, 16'd4, 1'b0);
        @(posedge clk);
        #1;
        check_val("f1_valid_drop", 64'(bus0.valid_o), 64'd0);

        // Same frame, sink stalls three cycles while the next beat waits.
        send(32'h0001_0000, 16'd11, 8'd4);
        send(32'h0001_0000, 16'd12, 8'd4);
        send(32'h0001_0000, 16'd13, 8'd4);
        bus0.ready_i = 1'b0;
        send(32'h0001_0000, 16'd14, 8'd4);
        check_frame("f2", 32'h0004_0000, 16'd14, 1'b0);
        bus0.in_i = 32'h0005_0000; bus0.user_i = 16'd21; bus0.len_i = 8'd1; bus0.valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("stall_ready", 64'(bus0.ready_o), 64'd0);
            check_val("stall_valid", 64'(bus0.valid_o), 64'd1);
            check_val("stall_out",   64'(bus0.out_o),   64'h0004_0000);
            check_val("stall_user",  64'(bus0.user_o),  64'd14);
            @(posedge clk);
            #1;
        end
        bus0.ready_i = 1'b1;
        send(32'h0005_0000, 16'd21, 8'd1);
        check_frame("f3", 32'h0005_0000, 16'd21, 1'b0);
        @(posedge clk);
        #1;
        check_val("f3_valid_drop", 64'(bus0.valid_o), 64'd0);
        @(posedge clk);
        #1;
        check_val("f3_no_dup", 64'(bus0.valid_o), 64'd0);

        // Unsigned overflow clamps, then len 0 behaves as len 1.
        send(32'hFFFF_0000, 16'd31, 8'd2);
        send(32'hFFFF_0000, 16'd32, 8'd2);
        check_frame("f4", 32'hFFFF_FFFF, 16'd32, 1'b1);
        send(32'h0002_0000, 16'd33, 8'd0);
        check_frame("f5", 32'h0002_0000, 16'd33, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset between clock edges aborts a half-built frame.
        send(32'h0001_0000, 16'd41, 8'd4);
        send(32'h0001_0000, 16'd42, 8'd4);
        #3 rstn = 1'b0;
        #1;
        $display("reset out=0x%08h valid=%0d", bus0.out_o, bus0.valid_o);
        check_val("arst_valid", 64'(bus0.valid_o), 64'd0);
        check_val("arst_out",   64'(bus0.out_o),   64'd0);
        check_val("arst_user",  64'(bus0.user_o),  64'd0);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0003_0000, 16'd51, 8'd1);
        check_frame("f6", 32'h0003_0000, 16'd51, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
